pipeline_stall_ctrl: RTL and testbench

PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

---
 rtl/pipeline_stall_ctrl.sv | 89 ++++++++
 tb/tb_pipeline_stall_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// IF/ID pipeline register with hazard stall, redirect flush, stall FSM and error/statistics counters.
// PCWrite/Bubble_ID_EX are combinational; IF/ID and status update on the next edge. Stall holds IF/ID and the PC.
module pipeline_stall_ctrl #(
    parameter int          MAX_STALL = 3,
    parameter logic [31:0] NOP_WORD  = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        HazardControl,
    input  logic [2:0]  PCSource,
    input  logic [31:0] Instruction_IF,
    input  logic [31:0] PC_plus4_IF,
    output logic        PCWrite,
    output logic [31:0] Instruction_IF_ID,
    output logic [31:0] PC_plus4_IF_ID,
    output logic        Bubble_ID_EX,
    output logic        Stalled,
    output logic        StallTimeout,
    output logic [15:0] StallCount,
    output logic [15:0] FlushCount
);

    typedef enum logic {RUN, STALL} state_t;

    localparam logic [31:0] MAX_STALL_U = 32'(MAX_STALL);

    state_t      state;
    logic [2:0]  pc_sel;
    logic        is_branch;
    logic        redirect;
    logic        stall;
    logic [3:0]  consec_cnt;
    logic [31:0] consec_next;

    // Reserved select codes behave exactly like sequential fetch.
    assign pc_sel    = (PCSource[2:1] == 2'b11) ? 3'b000 : PCSource;
    assign is_branch = (pc_sel == 3'b001);
    // A jr still waiting on its operand must not redirect until the hazard clears.
    assign redirect  = is_branch || (pc_sel == 3'b011) || (pc_sel == 3'b100) ||
                       (pc_sel == 3'b101) || ((pc_sel == 3'b010) && !HazardControl);
    assign stall     = HazardControl && !is_branch;

    assign PCWrite      = !stall;
    assign Bubble_ID_EX = HazardControl || is_branch;
    assign Stalled      = (state == STALL);

    assign consec_next = {28'd0, consec_cnt} + 32'd1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            Instruction_IF_ID <= NOP_WORD;
            PC_plus4_IF_ID    <= 32'd0;
            state             <= RUN;
            consec_cnt        <= 4'd0;
            StallTimeout      <= 1'b0;
            StallCount        <= 16'd0;
            FlushCount        <= 16'd0;
        end else begin
            if (redirect) begin
                Instruction_IF_ID <= NOP_WORD;
                PC_plus4_IF_ID    <= PC_plus4_IF;
            end else if (!stall) begin
                Instruction_IF_ID <= Instruction_IF;
                PC_plus4_IF_ID    <= PC_plus4_IF;
            end

            state <= stall ? STALL : RUN;

            if (stall) begin
                if (consec_cnt != 4'hF) begin
                    consec_cnt <= consec_cnt + 4'd1;
                end
                if (consec_next > MAX_STALL_U) begin
                    StallTimeout <= 1'b1;
                end
            end else begin
                consec_cnt <= 4'd0;
            end

            if (stall && (StallCount != 16'hFFFF)) begin
                StallCount <= StallCount + 16'd1;
            end
            if (redirect && (FlushCount != 16'hFFFF)) begin
                FlushCount <= FlushCount + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboarded random and directed bench for pipeline_stall_ctrl against a behavioural model.
module tb_pipeline_stall_ctrl;

    localparam int          MAX_STALL = 3;
    localparam logic [31:0] NOP_WORD  = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        HazardControl = 1'b0;
    logic [2:0]  PCSource = 3'd0;
    logic [31:0] Instruction_IF = 32'd0;
    logic [31:0] PC_plus4_IF = 32'd0;
    logic        PCWrite;
    logic [31:0] Instruction_IF_ID;
    logic [31:0] PC_plus4_IF_ID;
    logic        Bubble_ID_EX;
    logic        Stalled;
    logic        StallTimeout;
    logic [15:0] StallCount;
    logic [15:0] FlushCount;

    pipeline_stall_ctrl #(.MAX_STALL(MAX_STALL), .NOP_WORD(NOP_WORD)) dut (
        .clk(clk), .reset(reset), .HazardControl(HazardControl), .PCSource(PCSource),
        .Instruction_IF(Instruction_IF), .PC_plus4_IF(PC_plus4_IF), .PCWrite(PCWrite),
        .Instruction_IF_ID(Instruction_IF_ID), .PC_plus4_IF_ID(PC_plus4_IF_ID),
        .Bubble_ID_EX(Bubble_ID_EX), .Stalled(Stalled), .StallTimeout(StallTimeout),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pcw;
        logic        bub;
        logic        stl;
        logic        tmo;
        logic [31:0] inst;
        logic [31:0] pc4;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: what the registered outputs should be after the edges so far.
    logic [31:0] m_inst;
    logic [31:0] m_pc4;
    bit          m_stalled;
    bit          m_timeout;
    int          m_run;
    int          m_scnt;
    int          m_fcnt;

    task automatic model_reset();
        m_inst = NOP_WORD; m_pc4 = 32'd0; m_stalled = 0; m_timeout = 0;
        m_run = 0; m_scnt = 0; m_fcnt = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // One clock cycle of stimulus: apply inputs, predict this cycle's outputs, then advance the model past the edge.
    task automatic cyc(input bit r, input bit h, input int ps, input logic [31:0] ins, input logic [31:0] pc4);
        exp_t e;
        int   code;
        bit   br, st, rd;
        @(negedge clk);
        reset = r; HazardControl = h; PCSource = 3'(ps); Instruction_IF = ins; PC_plus4_IF = pc4;
        code = (ps >= 6) ? 0 : ps;
        br = (code == 1);
        st = h && !br;
        rd = (code == 1) || (code == 3) || (code == 4) || (code == 5) || (code == 2 && !h);
        e.pcw = !st; e.bub = h || br;
        e.stl = m_stalled; e.tmo = m_timeout; e.inst = m_inst; e.pc4 = m_pc4;
        e.sc = 16'(m_scnt); e.fc = 16'(m_fcnt);
        q.push_back(e);
        if (!r) begin
            model_reset();
        end else begin
            if (rd) begin
                m_inst = NOP_WORD; m_pc4 = pc4;
            end else if (!st) begin
                m_inst = ins; m_pc4 = pc4;
            end
            m_stalled = st;
            if (st) begin
                if (m_run + 1 > MAX_STALL) m_timeout = 1;
                m_run = (m_run + 1 > 15) ? 15 : m_run + 1;
            end else begin
                m_run = 0;
            end
            if (st && m_scnt < 65535) m_scnt++;
            if (rd && m_fcnt < 65535) m_fcnt++;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("PCWrite",           32'(PCWrite),      32'(e.pcw));
                chk("Bubble_ID_EX",      32'(Bubble_ID_EX), 32'(e.bub));
                chk("Stalled",           32'(Stalled),      32'(e.stl));
                chk("StallTimeout",      32'(StallTimeout), 32'(e.tmo));
                chk("Instruction_IF_ID", Instruction_IF_ID, e.inst);
                chk("PC_plus4_IF_ID",    PC_plus4_IF_ID,    e.pc4);
                chk("StallCount",        32'(StallCount),   32'(e.sc));
                chk("FlushCount",        32'(FlushCount),   32'(e.fc));
            end
        end
    end

    initial begin : driver
        int budget;
        // Two unchecked reset edges bring the DUT to a known state.
        repeat (2) @(negedge clk);
        model_reset();

        cyc(0, 0, 0, 32'h0, 32'h0);
        // Simple load, then observed on the next cycle.
        cyc(1, 0, 0, 32'h8C880004, 32'h00000104);
        cyc(1, 0, 0, 32'h00000001, 32'h00000108);
        // Single stall cycle.
        cyc(1, 1, 0, 32'h00000002, 32'h0000010C);
        cyc(1, 0, 0, 32'h00000003, 32'h00000110);
        // Taken branch overrides a hazard.
        cyc(1, 1, 1, 32'h00000004, 32'h00000114);
        cyc(1, 0, 0, 32'h00000005, 32'h00000118);
        // jr waits two hazard cycles, then flushes.
        cyc(0, 0, 0, 32'h0, 32'h0);
        cyc(1, 1, 2, 32'h00000006, 32'h0000011C);
        cyc(1, 1, 2, 32'h00000007, 32'h00000120);
        cyc(1, 0, 2, 32'h00000008, 32'h00000124);
        cyc(1, 0, 0, 32'h00000009, 32'h00000128);
        // Four consecutive stalls trip the sticky timeout.
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 32'hA0 + 32'(i), 32'h200);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 32'hB0 + 32'(i), 32'h204);
        // Reset in the middle of a five-cycle stall.
        for (int i = 0; i < 5; i++) cyc(1, 1, 0, 32'hC0, 32'h300);
        cyc(0, 1, 0, 32'hC1, 32'h304);
        cyc(1, 0, 0, 32'hC2, 32'h308);
        // Redirects of every kind, including reserved codes and j while hazarded.
        for (int p = 0; p < 8; p++) begin
            cyc(1, 0, p, 32'hD0 + 32'(p), 32'h400 + 32'(p));
            cyc(1, 1, p, 32'hE0 + 32'(p), 32'h500 + 32'(p));
        end

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1,
                ($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0,
                int'($urandom_range(0, 7)), $urandom, $urandom);
        end
        cyc(1, 0, 0, 32'h0, 32'h0);

        budget = 20;
        while (q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        #3;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
